// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative RV64M divide/remainder unit.
package divider_pkg;

  // Operation select, sampled when an operation is accepted.
  typedef enum logic [2:0] {
    DIV   = 3'd0,
    DIVU  = 3'd1,
    REM   = 3'd2,
    REMU  = 3'd3,
    DIVW  = 3'd4,
    DIVUW = 3'd5,
    REMW  = 3'd6,
    REMUW = 3'd7
  } divfunc_t;

  // Controller state, also exported on a debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Cycles from the accept cycle to the done pulse for a normal divide.
  localparam int DIV_LATENCY = 65;

  // Operation treats operands as two's-complement values.
  function automatic logic is_signed_op(input divfunc_t f);
    return (f == DIV) || (f == REM) || (f == DIVW) || (f == REMW);
  endfunction

  // Operation returns the remainder rather than the quotient.
  function automatic logic is_rem_op(input divfunc_t f);
    return (f == REM) || (f == REMU) || (f == REMW) || (f == REMUW);
  endfunction

  // Operation works on the low 32 bits and sign-extends its result.
  function automatic logic is_word_op(input divfunc_t f);
    return (f == DIVW) || (f == DIVUW) || (f == REMW) || (f == REMUW);
  endfunction

endpackage

// File: rtl/divider_core.sv
// Unsigned restoring shift-subtract datapath, one quotient bit per step.
// The dividend register doubles as the quotient register: each step shifts
// the dividend MSB into the partial remainder and the new quotient bit in
// at the LSB, so after WIDTH steps it holds the full quotient.
module div_core #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_next_o,
  output logic [WIDTH-1:0] rem_next_o
);

  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;

  // The shifted remainder keeps its top bit (WIDTH+1 bits) so that divisors
  // with the MSB set still compare correctly.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             ge;

  // Result of the step taken this cycle, visible before it is registered.
  always_comb begin
    rem_shift  = {rem_q, dq_q[WIDTH-1]};
    diff       = rem_shift - {1'b0, dvs_q};
    ge         = (rem_shift >= {1'b0, dvs_q});
    rem_next_o = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next_o = {dq_q[WIDTH-2:0], ge};
  end

  // Load operands on start, advance one bit on each step.
  always_ff @(posedge clk) begin
    if (reset) begin
      dq_q  <= '0;
      dvs_q <= '0;
      rem_q <= '0;
    end else if (start_i) begin
      dq_q  <= dividend_i;
      dvs_q <= divisor_i;
      rem_q <= '0;
    end else if (step_i) begin
      dq_q  <= quo_next_o;
      rem_q <= rem_next_o;
    end
  end

endmodule

// File: rtl/divider.sv
// RV64M divide/remainder unit: accept handshake, operand conditioning,
// special-case short-cut, iteration control and sign fixup.
//
// Handshake: an operation is accepted in a cycle where valid_i=1, ready_o=1
// and flush=0; divfunc/a/b are sampled in that cycle. valid_i seen while
// ready_o=0 is ignored, so a requester holds valid_i until ready_o=1.
// done_o pulses for one cycle with c valid; c then holds until the next
// operation completes. Flush returns to IDLE without touching c.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  divfunc_t         divfunc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             done_o,
  output logic [WIDTH-1:0] c,
  output div_state_t       state_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  divfunc_t         func_q, func_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] c_q, c_d;

  logic             op_signed, op_word, op_rem;
  logic [WIDTH-1:0] a_ext, b_ext;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] min_val;
  logic             div_zero, overflow, special;
  logic [WIDTH-1:0] special_res;

  logic             core_start, core_step;
  logic [WIDTH-1:0] quo_next, rem_next;
  logic [WIDTH-1:0] quo_fix, rem_fix, final_res;

  // Replace the upper bits with copies of bit 31 for word results.
  function automatic logic [WIDTH-1:0] word_fix(input logic word,
                                                input logic [WIDTH-1:0] v);
    return word ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
  endfunction

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .start_i    (core_start),
    .step_i     (core_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_next_o (quo_next),
    .rem_next_o (rem_next)
  );

  // Condition the incoming operands and spot the cases that need no division.
  always_comb begin
    op_signed = is_signed_op(divfunc);
    op_word   = is_word_op(divfunc);
    op_rem    = is_rem_op(divfunc);
    if (op_word) begin
      a_ext = op_signed ? {{(WIDTH-32){a[31]}}, a[31:0]} : {{(WIDTH-32){1'b0}}, a[31:0]};
      b_ext = op_signed ? {{(WIDTH-32){b[31]}}, b[31:0]} : {{(WIDTH-32){1'b0}}, b[31:0]};
      min_val = {{(WIDTH-32){1'b1}}, 1'b1, 31'b0};
    end else begin
      a_ext   = a;
      b_ext   = b;
      min_val = {1'b1, {(WIDTH-1){1'b0}}};
    end
    a_neg    = op_signed & a_ext[WIDTH-1];
    b_neg    = op_signed & b_ext[WIDTH-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    overflow = op_signed && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero | overflow;
    if (div_zero) begin
      special_res = op_rem ? a_ext : '1;
    end else begin
      special_res = op_rem ? '0 : a_ext;
    end
    special_res = word_fix(op_word, special_res);
  end

  // Sign fixup of the magnitude result produced by the final iteration.
  always_comb begin
    quo_fix   = (a_neg_q ^ b_neg_q) ? -quo_next : quo_next;
    rem_fix   = a_neg_q ? -rem_next : rem_next;
    final_res = word_fix(is_word_op(func_q), is_rem_op(func_q) ? rem_fix : quo_fix);
  end

  // Next-state logic: accept in IDLE/DONE, iterate in BUSY, flush overrides.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    func_d     = func_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    c_d        = c_q;
    core_start = 1'b0;
    core_step  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (valid_i) begin
            func_d  = divfunc;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            if (special) begin
              state_d = DONE;
              c_d     = special_res;
            end else begin
              state_d    = BUSY;
              cnt_d      = '0;
              core_start = 1'b1;
            end
          end
        end
        BUSY: begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            c_d     = final_res;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      func_q  <= DIV;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      c_q     <= c_d;
    end
  end

  assign ready_o = (state_q != BUSY);
  assign done_o  = (state_q == DONE);
  assign c       = c_q;
  assign state_o = state_q;

endmodule
